// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared types and sizes for the register-bank writeback arbiter.
package regbank_wb_arbiter_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arbState_t;

  // Registered write port presented to the register bank.
  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] rw;
    logic [DATA_W-1:0]     d;
  } wrPort_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone eligible source wins, a tie goes to the
// source that was not granted last. Purely combinational.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_gnt,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |eligible;
    winner = 1'b0;
    case (eligible)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Writeback arbiter for the register bank: clears all registers after reset,
// then arbitrates ALU/load writebacks. Optional forwarding via REGARB_FWD_EN.
module regbank_wb_arbiter
  import regbank_wb_arbiter_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [REG_ADDR_W-1:0] addr0,
  input  logic [REG_ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0]     data0,
  input  logic [DATA_W-1:0]     data1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] rw,
  output logic [DATA_W-1:0]     d,
  output logic                  init_done,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  output logic                  fwdA_hit,
  output logic                  fwdB_hit,
  output logic [DATA_W-1:0]     fwdA_data,
  output logic [DATA_W-1:0]     fwdB_data
);

  localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

  arbState_t             state, stateNext;
  logic [REG_ADDR_W-1:0] cnt, cntNext;
  logic                  lastGnt, lastGntNext;
  wrPort_t               port, portNext;
  logic                  gnt0Next, gnt1Next, initDoneNext;

  logic [1:0]            eligible;
  logic                  winner, winValid;
  logic [REG_ADDR_W-1:0] winAddr;
  logic [DATA_W-1:0]     winData;

  // A source granted this cycle is still showing its old request; mask it.
  assign eligible = {req1 & ~gnt1, req0 & ~gnt0};

  rr_arb2 uArb (
    .eligible (eligible),
    .last_gnt (lastGnt),
    .winner   (winner),
    .valid    (winValid)
  );

  assign winAddr = winner ? addr1 : addr0;
  assign winData = winner ? data1 : data0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      cnt       <= '0;
      lastGnt   <= 1'b1;
      port      <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      lastGnt   <= lastGntNext;
      port      <= portNext;
      gnt0      <= gnt0Next;
      gnt1      <= gnt1Next;
      init_done <= initDoneNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    lastGntNext  = lastGnt;
    portNext     = port;
    portNext.we  = 1'b0;
    gnt0Next     = 1'b0;
    gnt1Next     = 1'b0;
    initDoneNext = init_done;

    case (state)
      INIT: begin
        portNext = '{we: 1'b1, rw: cnt, d: INIT_VAL};
        cntNext  = cnt + REG_ADDR_W'(1);
        if (cnt == LAST_REG) begin
          stateNext    = RUN;
          initDoneNext = 1'b1;
        end
      end
      RUN: begin
        if (winValid) begin
          gnt0Next    = ~winner;
          gnt1Next    = winner;
          lastGntNext = winner;
          // Register 0 is hardwired zero: grant the source but suppress the write.
          portNext.we = (winAddr != '0);
          portNext.rw = winAddr;
          portNext.d  = winData;
        end
      end
      default: stateNext = INIT;
    endcase
  end

  assign we = port.we;
  assign rw = port.rw;
  assign d  = port.d;

`ifdef REGARB_FWD_EN
  always_comb begin
    fwdA_hit  = port.we && (port.rw != '0) && (port.rw == ra);
    fwdB_hit  = port.we && (port.rw != '0) && (port.rw == rb);
    fwdA_data = fwdA_hit ? port.d : '0;
    fwdB_data = fwdB_hit ? port.d : '0;
  end
`else
  logic unusedReadAddr;
  assign unusedReadAddr = ^{ra, rb};
  assign fwdA_hit  = 1'b0;
  assign fwdB_hit  = 1'b0;
  assign fwdA_data = '0;
  assign fwdB_data = '0;
`endif

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Randomized scoreboard bench for regbank_wb_arbiter (default or REGARB_FWD_EN build).
module tb_regbank_wb_arbiter;

  localparam logic [31:0] INIT_VAL = 32'hA5A5_0F0F;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  gap;
  } txn_t;

  logic        clk, rst;
  logic        req0, req1;
  logic [4:0]  addr0, addr1, ra, rb, rw;
  logic [31:0] data0, data1, d, fwdA_data, fwdB_data;
  logic        gnt0, gnt1, we, init_done, fwdA_hit, fwdB_hit;

  int nAssert = 0;
  int nFail   = 0;
  bit runPhase = 1'b0;
  int grantLog[$];

  regbank_wb_arbiter #(.INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
    .we(we), .rw(rw), .d(d), .init_done(init_done),
    .ra(ra), .rb(rb), .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit),
    .fwdA_data(fwdA_data), .fwdB_data(fwdB_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One driver per source: holds each request until its grant is seen.
  for (genvar g = 0; g < 2; g++) begin : src
    logic        req;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gnt;
    txn_t        txQ[$];
    txn_t        expQ[$];

    assign gnt = (g == 0) ? gnt0 : gnt1;

    initial begin
      txn_t cur;
      bit   have;
      int   waitCnt;
      req = 1'b0; addr = '0; data = '0;
      have = 1'b0; waitCnt = 0; cur = '0;
      forever begin
        @(posedge clk); #1;
        if (req && gnt) begin
          check("grant_latency", 32'(waitCnt <= 2), 1);
          req  = 1'b0;
          have = 1'b0;
        end
        if (!req) begin
          if (!have && txQ.size() > 0) begin
            cur  = txQ.pop_front();
            have = 1'b1;
          end
          if (have) begin
            if (cur.gap == 4'd0) begin
              req  = 1'b1;
              addr = cur.addr;
              data = cur.data;
              expQ.push_back(cur);
              waitCnt = 0;
            end else begin
              cur.gap = cur.gap - 4'd1;
            end
          end
        end else if (runPhase) begin
          waitCnt++;
          if (waitCnt > 4) begin
            check("grant_timeout", 0, 1);
            req  = 1'b0;
            have = 1'b0;
            expQ.delete();
          end
        end
      end
    end
  end

  assign req0  = src[0].req;
  assign addr0 = src[0].addr;
  assign data0 = src[0].data;
  assign req1  = src[1].req;
  assign addr1 = src[1].addr;
  assign data1 = src[1].data;

  function automatic txn_t mkTx(input logic [4:0] a, input logic [31:0] dt, input logic [3:0] gp);
    txn_t t;
    t.addr = a;
    t.data = dt;
    t.gap  = gp;
    return t;
  endfunction

  task automatic pushTx(input int id, input txn_t t);
    if (id == 0) src[0].txQ.push_back(t);
    else         src[1].txQ.push_back(t);
  endtask

  function automatic bit allIdle();
    return (src[0].txQ.size() == 0) && (src[1].txQ.size() == 0) &&
           (src[0].expQ.size() == 0) && (src[1].expQ.size() == 0) && !req0 && !req1;
  endfunction

  // Monitor + reference model: predicts next cycle's grant from the requests
  // seen now, then checks the write port against the popped transaction.
  bit         havePred = 1'b0, expAny = 1'b0, expW = 1'b0, mdlLast = 1'b1, holdKnown = 1'b0;
  logic [4:0]  mdlRw = '0;
  logic [31:0] mdlD  = '0;

  initial begin
    txn_t        t;
    bit          c0, c1, wExp, hitA, hitB;
    logic [4:0]  wRw;
    logic [31:0] wD;
    forever begin
      @(negedge clk);
      if (rst) begin
        havePred = 1'b0; mdlLast = 1'b1; holdKnown = 1'b0; expAny = 1'b0;
      end else if (runPhase) begin
        wExp = 1'b0; wRw = '0; wD = '0;
        if (havePred) begin
          check("gnt0", 32'(gnt0), 32'(expAny && !expW));
          check("gnt1", 32'(gnt1), 32'(expAny && expW));
          if (expAny) begin
            if ((expW ? src[1].expQ.size() : src[0].expQ.size()) == 0) begin
              check("scoreboard_underflow", 0, 1);
            end else begin
              if (expW) t = src[1].expQ.pop_front();
              else      t = src[0].expQ.pop_front();
              wExp = (t.addr != 5'd0);
              wRw  = t.addr;
              wD   = t.data;
              check("we", 32'(we), 32'(wExp));
              if (wExp) begin
                check("rw", 32'(rw), 32'(t.addr));
                check("d", d, t.data);
              end
              mdlRw = t.addr; mdlD = t.data; holdKnown = wExp;
            end
          end else begin
            check("we_idle", 32'(we), 0);
            if (holdKnown) begin
              check("rw_hold", 32'(rw), 32'(mdlRw));
              check("d_hold", d, mdlD);
            end
          end
`ifdef REGARB_FWD_EN
          hitA = wExp && (wRw == ra);
          hitB = wExp && (wRw == rb);
`else
          hitA = 1'b0;
          hitB = 1'b0;
`endif
          check("fwdA_hit", 32'(fwdA_hit), 32'(hitA));
          check("fwdB_hit", 32'(fwdB_hit), 32'(hitB));
          check("fwdA_data", fwdA_data, hitA ? wD : 32'h0);
          check("fwdB_data", fwdB_data, hitB ? wD : 32'h0);
        end
        c0 = req0 && !(havePred && expAny && !expW);
        c1 = req1 && !(havePred && expAny && expW);
        expAny = c0 || c1;
        expW   = (c0 && c1) ? !mdlLast : c1;
        if (expAny) mdlLast = expW;
        havePred = 1'b1;
      end
      if (gnt0) grantLog.push_back(0);
      if (gnt1) grantLog.push_back(1);
    end
  end

  task automatic checkSweep(input int n, input bit goRun);
    for (int k = 0; k < n; k++) begin
      check("sweep_we", 32'(we), 1);
      check("sweep_rw", 32'(rw), 32'(k));
      check("sweep_d", d, INIT_VAL);
      check("sweep_gnt", 32'({gnt0, gnt1}), 0);
      check("sweep_done", 32'(init_done), 32'(k == 31));
      if (goRun && k == 31) runPhase = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic checkCleared(input string tag);
    check({tag, "_gnt"}, 32'({gnt0, gnt1}), 0);
    check({tag, "_we"}, 32'(we), 0);
    check({tag, "_rw"}, 32'(rw), 0);
    check({tag, "_d"}, d, 0);
    check({tag, "_init_done"}, 32'(init_done), 0);
    check({tag, "_fwd"}, 32'({fwdA_hit, fwdB_hit}), 0);
    check({tag, "_fwd_data"}, fwdA_data | fwdB_data, 0);
  endtask

  task automatic waitDrain(input int maxCyc, input bit randRd);
    int n = 0;
    while (!allIdle() && n < maxCyc) begin
      @(posedge clk); #1;
      if (randRd) begin
        ra = 5'($urandom_range(0, 12));
        rb = 5'($urandom_range(0, 12));
      end
      n++;
    end
    check("drain", 32'(allIdle()), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ra = '0; rb = '0;
    repeat (3) @(posedge clk);
    #1;
    checkCleared("reset");

    // Full sweep with no traffic, then idle.
    rst = 1'b0;
    @(posedge clk); #1;
    checkSweep(32, 1'b1);
    check("post_sweep_we", 32'(we), 0);
    check("post_sweep_done", 32'(init_done), 1);

    // Directed single writes: normal, register 0, forwarding target.
    pushTx(0, mkTx(5'd5, 32'hDEAD_BEEF, 4'd0));
    waitDrain(50, 1'b0);
    pushTx(1, mkTx(5'd0, 32'h1111_2222, 4'd0));
    waitDrain(50, 1'b0);
    ra = 5'd7; rb = 5'd3;
    pushTx(0, mkTx(5'd7, 32'hCAFE_0007, 4'd0));
    waitDrain(50, 1'b0);
    ra = '0; rb = '0;

    // Reset in cycle 10 of a sweep, then full restart with both sources pending.
    runPhase = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkSweep(10, 1'b0);
    check("pre_reset_rw", 32'(rw), 10);
    rst = 1'b1;
    #1;
    checkCleared("mid_sweep_reset");
    grantLog.delete();
    for (int i = 0; i < 3; i++) begin
      pushTx(0, mkTx(5'(i + 1), $urandom(), 4'd0));
      pushTx(1, mkTx(5'(i + 20), $urandom(), 4'd0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkSweep(32, 1'b1);
    waitDrain(50, 1'b0);
    check("alternate_count", 32'(grantLog.size()), 6);
    for (int i = 0; i < 6 && i < grantLog.size(); i++)
      check("alternate_order", 32'(grantLog[i]), 32'(i % 2));

    // Randomized traffic with random gaps, register-0 writes and read ports.
    for (int i = 0; i < 150; i++) begin
      for (int s = 0; s < 2; s++) begin
        logic [4:0] a;
        a = ($urandom_range(0, 7) == 0) ? 5'd0 :
            (($urandom_range(0, 1) == 0) ? 5'($urandom_range(1, 12)) : 5'($urandom_range(1, 31)));
        pushTx(s, mkTx(a, $urandom(), 4'($urandom_range(0, 3))));
      end
    end
    waitDrain(4000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 Parameter: INIT_VAL, 32'h0000_0000, value written to every register during the post-reset sweep.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: req0/req1  in  1 each  write request from source 0 (ALU writeback) / source 1 (load writeback).
REQ-005 Port: addr0/addr1  in  5 each  destination register of each source.
REQ-006 Port: data0/data1  in  32 each  write data of each source.
REQ-007 Port: gnt0/gnt1  out  1 each  one-cycle registered grant pulse.
REQ-008 Port: we, rw, d  out  1/5/32  registered write port driving the register bank.
REQ-009 Port: init_done  out  1  high once the sweep completes.
REQ-010 Port: ra, rb  in  5 each  bank read addresses, used for forwarding.
REQ-011 Port: fwdA_hit, fwdB_hit  out  1 each; fwdA_data, fwdB_data  out  32 each  forwarding results.

Function
REQ-012 FSM states: INIT, RUN; reset enters INIT.
REQ-013 INIT: 5-bit counter cnt from 0; each cycle we=1, rw=cnt, d=INIT_VAL, gnt0=gnt1=0.
REQ-014 INIT -> RUN after the cycle with cnt=31 (32 write cycles); init_done=1 from the first RUN cycle on.
REQ-015 RUN: eligible_i = req_i and not gnt_i (a source granted this cycle is masked for this cycle).
REQ-016 RUN: with one eligible source, it wins; with both eligible, round-robin: winner is the source not granted last (last_gnt register, reset 1, so source 0 wins the first tie).
REQ-017 Winner registered at the edge: next cycle gnt_w=1, we=1, rw=addr_w, d=data_w; last_gnt updates to w.
REQ-018 Source request held stable until gnt seen; source deasserts or changes addr/data in the cycle after gnt.
REQ-019 Winner addr=0: gnt still pulses, we=0 ($zero never written).
REQ-020 No eligible source: we=0, gnts 0, rw/d hold previous values.
REQ-021 Requests during INIT are ignored and remain pending; arbitration starts in the first RUN cycle (first grant visible one cycle later).
REQ-022 Throughput: both sources continuously requesting -> alternating grants, one write per cycle.

Reset
REQ-023 rst asserted at any time (including mid-sweep or mid-grant): immediately state=INIT, cnt=0, last_gnt=1, gnt0=gnt1=0, we=0, rw=0, d=0, init_done=0, fwd outputs 0; the sweep restarts in full after release.

Configuration
REQ-024 Macro REGARB_FWD_EN defined: fwdX_hit = we and rw!=0 and rw==raX (ra for A, rb for B), combinational; fwdX_data = d when hit, else 0.
REQ-025 REGARB_FWD_EN undefined: ra/rb unused, fwd outputs constant 0, no compare logic.

Structure
REQ-026 Shared package holds: FSM state enum (INIT, RUN), REG_ADDR_W=5, DATA_W=32, NUM_REGS=32.
REQ-027 One sub-module rr_arb2 (2-way round-robin, inputs eligible[1:0] and last_gnt, output winner and valid), purely combinational, instantiated once.

Verification
REQ-028 Release reset, no requests -> we=1 for 32 cycles with rw 0..31, d=INIT_VAL, then init_done=1, we=0.
REQ-029 RUN, req0 only, addr0=5, data0=32'hDEAD_BEEF -> next cycle gnt0=1, we=1, rw=5, d=32'hDEAD_BEEF; req0 dropped -> we=0.
REQ-030 RUN, req0 and req1 held high continuously -> gnt0, gnt1, gnt0, gnt1 alternating, one per cycle, first grant to source 0.
REQ-031 req1 with addr1=0 -> gnt1=1, we=0.
REQ-032 Assert rst during cycle 10 of the sweep -> outputs clear that cycle; after release the sweep restarts at rw=0 and runs 32 cycles.
REQ-033 With REGARB_FWD_EN: write to rw=7, ra=7, rb=3 -> fwdA_hit=1, fwdA_data=d, fwdB_hit=0; without the macro both hits are 0.
